// File: rtl/demux_3outputs_16bits_pkg.sv
// Shared types and sizes for the CPU result router: destination codes and
// drop-counter width.
package cpu_route_pkg;

  localparam int DATA_W     = 16;
  localparam int NUM_DEST   = 3;
  localparam int DROP_CNT_W = 8;

  typedef enum logic [2:0] {
    SEL_D0 = 3'b000,
    SEL_D1 = 3'b001,
    SEL_D2 = 3'b010
  } dest_sel_t;

endpackage

// File: rtl/demux_3outputs_16bits_if.sv
// Upstream handshake, three downstream handshakes and drop status of the
// result router, bundled as one interface.
interface demux_3outputs_16bits_if
  import cpu_route_pkg::*;
#(
  parameter int WIDTH = DATA_W
) ();

  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      in_data;
  logic [2:0]            in_select;
  logic [NUM_DEST-1:0]   out_valid;
  logic [NUM_DEST-1:0]   out_ready;
  logic [WIDTH-1:0]      out_data0;
  logic [WIDTH-1:0]      out_data1;
  logic [WIDTH-1:0]      out_data2;
  logic [DROP_CNT_W-1:0] drop_count;
  logic                  drop_flag;
  logic                  drop_clear;

  modport slave (
    input  in_valid, in_data, in_select, out_ready, drop_clear,
    output in_ready, out_valid, out_data0, out_data1, out_data2,
           drop_count, drop_flag
  );

  modport master (
    output in_valid, in_data, in_select, out_ready, drop_clear,
    input  in_ready, out_valid, out_data0, out_data1, out_data2,
           drop_count, drop_flag
  );

endinterface

// File: rtl/demux_3outputs_16bits_route_fifo.sv
// Small synchronous FIFO for one router destination; head reads as zero
// while the queue is empty.
module route_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit distinguishes full from empty when the indices match.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= wdata;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/demux_3outputs_16bits.sv
// Buffered 1-to-3 result router: steers each accepted word to one of three
// destination queues by select code, and counts words with unused codes.
module demux_3outputs_16bits
  import cpu_route_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  demux_3outputs_16bits_if.slave  bus
);

  logic [NUM_DEST-1:0] full;
  logic [NUM_DEST-1:0] empty;
  logic [NUM_DEST-1:0] sel_oh;
  logic [NUM_DEST-1:0] push;
  logic [WIDTH-1:0]    head [NUM_DEST];
  logic                sel_ok;
  logic                rdy;
  logic                accept;
  logic                drop;
  logic [DROP_CNT_W-1:0] drop_cnt;
  logic                drop_seen;

  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  // Unused codes are always accepted so a bad select never stalls upstream.
  always_comb begin
    sel_ok = 1'b0;
    sel_oh = '0;
    rdy    = 1'b1;
    case (bus.in_select)
      SEL_D0:  begin sel_ok = 1'b1; sel_oh = 3'b001; end
      SEL_D1:  begin sel_ok = 1'b1; sel_oh = 3'b010; end
      SEL_D2:  begin sel_ok = 1'b1; sel_oh = 3'b100; end
      default: begin sel_ok = 1'b0; sel_oh = '0;     end
    endcase
    if (sel_ok) begin
      rdy = ~|(full & sel_oh);
    end
  end

  assign accept = bus.in_valid && rdy;
  assign push   = accept ? sel_oh : '0;
  assign drop   = accept && !sel_ok;

  for (genvar g = 0; g < NUM_DEST; g++) begin : g_dest
    route_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push[g]),
      .wdata (bus.in_data),
      .pop   (bus.out_ready[g]),
      .full  (full[g]),
      .empty (empty[g]),
      .head  (head[g])
    );
  end

  // A clear wins over a drop arriving in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt  <= '0;
      drop_seen <= 1'b0;
    end else if (bus.drop_clear) begin
      drop_cnt  <= '0;
      drop_seen <= 1'b0;
    end else if (drop) begin
      drop_cnt  <= sat_inc(drop_cnt);
      drop_seen <= 1'b1;
    end
  end

  assign bus.in_ready   = rdy;
  assign bus.out_valid  = ~empty;
  assign bus.out_data0  = head[0];
  assign bus.out_data1  = head[1];
  assign bus.out_data2  = head[2];
  assign bus.drop_count = drop_cnt;
  assign bus.drop_flag  = drop_seen;

endmodule

// File: doc/demux_3outputs_16bits.md
# demux_3outputs_16bits

Buffered 1-to-3 router for 16-bit results in the CPU core: the inverse of the 3-input result mux. It accepts one word per cycle on a valid/ready handshake, steers it by a 3-bit select code to one of three destination queues, and each destination drains its queue on its own valid/ready handshake. Words with an unused select code are consumed and counted as drops, so upstream never stalls on a bad code.

## Interface
- WIDTH, 16, data width of every word.
- DEPTH, 2, entries per destination queue; power of two, at least 2.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous assert, active-low.
- in_valid  input  1  upstream word present.
- in_ready  output  1  router accepts this cycle.
- in_data  input  WIDTH  word to route.
- in_select  input  3  destination code: 3'b000 selects dest0, 3'b001 selects dest1, 3'b010 selects dest2, anything else is a drop.
- out_valid  output  3  bit i: dest i queue non-empty.
- out_ready  input  3  bit i: dest i consumes head this cycle.
- out_data0 / out_data1 / out_data2  output  WIDTH  head word of each queue.
- drop_count  output  8  number of dropped words, saturating.
- drop_flag  output  1  sticky: at least one drop since reset or clear.
- drop_clear  input  1  synchronous clear of drop_count and drop_flag.

## Operation
- Accept occurs when in_valid && in_ready.
- in_ready rules:
  - Valid select code: in_ready = !full[select].
  - Invalid code: in_ready = 1.
  - in_ready depends combinationally on in_select. It has no dependence on out_ready and no pop-through when the queue is full.
- On accept with a valid code, in_data is pushed to the tail of the selected queue. Order is preserved per destination. There is no ordering between destinations.
- On accept with an invalid code, the word is discarded.
  - drop_count increments and saturates at 255.
  - drop_flag is set.
- Pop: dest i pops its head when out_valid[i] && out_ready[i]. out_ready while empty has no effect.
- out_dataN equals the head entry when out_valid[N] = 1, and 0 when the queue is empty.
- Simultaneous push and pop on one queue (allowed when not full) leaves occupancy unchanged. The pushed word follows any existing entries.
- Each queue keeps separate read and write pointers, each $clog2(DEPTH)+1 bits. Pointers wrap modulo 2*DEPTH.
  - full: pointers equal except the MSB.
  - empty: pointers fully equal.
- drop_clear has priority over a same-cycle drop. The result is count 0 and flag 0.
- Reset mid-operation clears all of the following: queue contents, pointers, out_valid, out_data, drop_count, drop_flag. Words in flight are lost, with no error indication.

## Timing
- Reset values:
  - in_ready = 1, whatever the select code.
  - out_valid = 3'b000.
  - out_data0/1/2 = 0.
  - drop_count = 0.
  - drop_flag = 0.
- Latency: a word accepted at edge N raises out_valid at edge N (visible in cycle N+1). There is no same-cycle bypass from in_data to out_data.
- Throughput: one accept per cycle. Each queue pops at most one word per cycle, and all three queues can pop in the same cycle.
- Full behaviour: DEPTH words can be queued per destination. The (DEPTH+1)th word to a full destination stalls upstream until the cycle after a pop.
- drop_count and drop_flag update at the accept edge.

## Structure
- Package cpu_route_pkg holds:
  - DATA_W = 16 and NUM_DEST = 3.
  - typedef enum logic [2:0] dest_sel_t with SEL_D0 = 3'b000, SEL_D1 = 3'b001, SEL_D2 = 3'b010.
  - DROP_CNT_W = 8.
- Sub-module route_fifo: a WIDTH x DEPTH synchronous FIFO with push/pop, full/empty and zeroed head output when empty. It is instantiated three times.
- The top level holds the select decode, in_ready mux and drop counter.

## Test plan
- Reset, then push 0x1234 with select 000 → out_valid = 001 next cycle, out_data0 = 0x1234. Pop with out_ready = 001 → out_valid = 000 and out_data0 = 0.
- Push 0xAAAA and 0xBBBB to dest1 with out_ready = 0 → in_ready drops to 0 for select 001 but stays 1 for select 000. A third word to dest1 is held until one out_ready[1] pulse, then accepted. Drain order is 0xAAAA, 0xBBBB, third word.
- Push 0x0001/0x0002/0x0003 interleaved across all three dests, then set out_ready = 111 → all three pop in one cycle with correct per-destination data.
- Select 011, 111 and 100 for 300 accepts → in_ready stays 1, no out_valid, drop_count = 255, drop_flag = 1. Then drop_clear and a drop in the same cycle → count 0, flag 0.
- With dest2 holding one word, push and pop dest2 in the same cycle → occupancy stays 1 and the new word is at the head next cycle.
- Assert rst_n low mid-burst with queues partly full → all outputs return to reset values immediately, and a post-reset push behaves as in the first scenario.
